pdm_cic_decimator: RTL and testbench
====================================

// Module: pdm_cic_decimator
// PURPOSE
//  Receive side of the 1-bit PDM audio path: converts a 1-bit PDM stream (pin input, density-coded)
//  into 16-bit signed PCM samples. 3rd-order CIC decimator with input synchronizer, sequential comb
//  pipeline and valid/ready output handshake. Sits between the PDM input pin and the audio sample bus.
//  Bit polarity matches the PDM DAC: high density of 1s = positive full scale.
// PARAMETERS
//  DECIM_LOG2  8   log2 of decimation ratio R (legal 4..10); R=256 -> 62.5 kHz at 16 MHz, ce tied high
//  OUT_W       16  PCM output width, two's complement
// PORTS
//  clk          in   1      system clock (16 MHz)
//  rst_n        in   1      synchronous reset, active low
//  pdm_in       in   1      asynchronous PDM bit from pin
//  pdm_ce       in   1      PDM sample enable; one PDM bit consumed per clk with pdm_ce=1
//  pcm_out      out  OUT_W  decoded signed PCM sample
//  pcm_valid    out  1      pcm_out holds an unconsumed sample
//  pcm_ready    in   1      consumer accepts sample when pcm_valid & pcm_ready
//  overrun      out  1      sticky: a sample was overwritten before being consumed
// BEHAVIOUR
//  Reset: synchronous, rst_n=0 sampled at clk edge clears sync flops, integrators, comb delays,
//   dec_cnt, warm-up count, FSM->IDLE; pcm_out=0, pcm_valid=0, overrun=0. Mid-operation reset
//   abandons any in-flight comb computation; nothing is emitted from it.
//  Sync: pdm_in through 2 flops -> pdm_s (2 clk latency). Sync flops run regardless of pdm_ce.
//  Input map: pdm_s=1 -> x=+1, 0 -> x=-1, sign-extended to ACC_W = 3*DECIM_LOG2+2 bits (26 default).
//  Integrators (only when pdm_ce=1): i1+=x; i2+=i1; i3+=i2, all updated same cycle from old values;
//   modular wrap-around mod 2^ACC_W is required (no saturation). pdm_ce=0: integrators, dec_cnt hold.
//  Decimation: dec_cnt (DECIM_LOG2 bits) increments on pdm_ce; when pdm_ce=1 and dec_cnt=all-ones
//   (wraps to 0) the post-update i3 is captured into cap and FSM leaves IDLE (a "tick").
//  Comb FSM (one stage per clk, independent of pdm_ce):
//   IDLE -tick-> C1: c1=cap-d1, d1<=cap -> C2: c2=c1-d2, d2<=c1 -> C3: c3=c2-d3, d3<=c2 -> OUT -> IDLE.
//   Tick-to-pcm_valid latency: 4 clk. Tick period >= 16 clk so no tick arrives outside IDLE.
//  Scaling: y = c3 >>> (ACC_W-1-OUT_W) (arith); saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//   Full-scale +R^3 maps to 0x7FFF (via saturation), -R^3 to 0x8000.
//  Warm-up: first 3 ticks after reset run the comb (delays fill) but emit nothing; 4th tick onward emits.
//  Output (OUT state): pcm_out<=y, pcm_valid<=1. If pcm_valid=1 and pcm_ready=0 that cycle ->
//   overwrite and set overrun (sticky until reset). If pcm_ready=1 same cycle -> old sample consumed,
//   new loaded, pcm_valid stays 1, no overrun.
//  Otherwise pcm_valid & pcm_ready -> pcm_valid<=0 next cycle; pcm_out holds last value.
// TESTING
//  1. pdm_in=1 const, pdm_ce=1, R=256 -> after warm-up pcm_out=0x7FFF, pcm_valid every 256 clk.
//  2. pdm_in=0 const -> pcm_out=0x8000 each emitted sample; overrun stays 0 with pcm_ready=1.
//  3. pdm_in alternating 1,0 -> pcm_out=0x0000 exactly once settled.
//  4. Loopback from PDM DAC with dac_in=16'h4000 -> settled pcm_out within 0x4000 +/- 64.
//  5. pcm_ready=0 over two emits -> overrun=1, pcm_out=2nd sample; ready=1 on emit cycle -> overrun=0.
//  6. rst_n=0 one clk while FSM in C2 -> next cycle all outputs 0; first pcm_valid 4 clk after 4th tick.
//  7. pdm_ce=1 every 4th clk -> same values as 1-3, emit period 1024 clk; integrators frozen between.

Source files
------------

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: 1-bit PDM to signed PCM converter.
// Two-flop input synchronizer, three integrators running at the PDM bit rate,
// a single time-shared comb stage sequenced by a small FSM at the decimated
// rate, output scaling with saturation, and a valid/ready sample register
// with a sticky overrun flag.
module pdm_cic_decimator #(
    parameter int DECIM_LOG2 = 8,
    parameter int OUT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pdm_in,
    input  logic             pdm_ce,
    output logic [OUT_W-1:0] pcm_out,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic             overrun
);

    // Bit growth of a 3rd-order CIC is 3*log2(R); one more bit for the
    // +/-1 input and one for sign headroom.
    localparam int ACC_W = 3 * DECIM_LOG2 + 2;
    localparam int SHIFT = ACC_W - 1 - OUT_W;

    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_C1,
        S_C2,
        S_C3,
        S_OUT
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, sync2_q;
    logic [ACC_W-1:0]        i1_q, i2_q, i3_q;
    logic [ACC_W-1:0]        i1_d, i2_d, i3_d;
    logic [ACC_W-1:0]        x;
    logic [DECIM_LOG2-1:0]   dec_cnt_q;
    logic [ACC_W-1:0]        cap_q, d1_q, d2_q, d3_q, comb_q;
    logic [1:0]              warm_q;
    logic [OUT_W-1:0]        pcm_out_q;
    logic                    pcm_valid_q, overrun_q;
    logic                    tick;
    logic                    emit;
    logic signed [ACC_W-1:0] y_wide;
    logic [OUT_W-1:0]        y_sat;

    // Density-coded bit: 1 -> +1, 0 -> -1 (all ones in two's complement).
    assign x    = sync2_q ? ACC_W'(1) : '1;
    assign tick = pdm_ce && (dec_cnt_q == '1);
    assign emit = (state_q == S_OUT) && (warm_q == 2'd3);

    // Integrator cascade; each stage adds the previous stage's old value.
    always_comb begin
        i1_d = i1_q + x;
        i2_d = i2_q + i1_q;
        i3_d = i3_q + i2_q;
    end

    // Two-flop synchronizer for the asynchronous pin, free-running.
    // NOTE: every register here uses <= so all flops sample old values on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pdm_in;
            sync2_q <= sync1_q;
        end
    end

    // Integrators and decimation counter advance only on PDM enable; wrap is intended.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i1_q      <= '0;
            i2_q      <= '0;
            i3_q      <= '0;
            dec_cnt_q <= '0;
        end else if (pdm_ce) begin
            i1_q      <= i1_d;
            i2_q      <= i2_d;
            i3_q      <= i3_d;
            dec_cnt_q <= dec_cnt_q + DECIM_LOG2'(1);
        end
    end

    // Comb sequencer next state: one comb stage per clock after each tick.
    // NOTE: state_d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (tick) state_d = S_C1;
            S_C1:    state_d = S_C2;
            S_C2:    state_d = S_C3;
            S_C3:    state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Capture and shared comb datapath; modular subtraction undoes integrator wrap.
    // NOTE: the comb delay registers are reset too, so the first outputs after reset are deterministic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_q  <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            d3_q   <= '0;
            comb_q <= '0;
        end else begin
            if ((state_q == S_IDLE) && tick) cap_q <= i3_d;
            case (state_q)
                S_C1: begin
                    comb_q <= cap_q - d1_q;
                    d1_q   <= cap_q;
                end
                S_C2: begin
                    comb_q <= comb_q - d2_q;
                    d2_q   <= comb_q;
                end
                S_C3: begin
                    comb_q <= comb_q - d3_q;
                    d3_q   <= comb_q;
                end
                default: ;
            endcase
        end
    end

    assign y_wide = $signed(comb_q) >>> SHIFT;

    // Saturate the scaled comb result into the PCM range (+R^3 lands just above max).
    always_comb begin
        y_sat = y_wide[OUT_W-1:0];
        if (y_wide > Y_MAX)      y_sat = Y_MAX[OUT_W-1:0];
        else if (y_wide < Y_MIN) y_sat = Y_MIN[OUT_W-1:0];
    end

    // Warm-up counting, sample register, valid/ready handshake and sticky overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            warm_q      <= 2'd0;
            pcm_out_q   <= '0;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if ((state_q == S_OUT) && (warm_q != 2'd3)) warm_q <= warm_q + 2'd1;
            if (emit) begin
                pcm_out_q   <= y_sat;
                pcm_valid_q <= 1'b1;
                if (pcm_valid_q && !pcm_ready) overrun_q <= 1'b1;
            end else if (pcm_valid_q && pcm_ready) begin
                pcm_valid_q <= 1'b0;
            end
        end
    end

    assign pcm_out   = pcm_out_q;
    assign pcm_valid = pcm_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb_pdm_cic_decimator: directed stimulus against a convolution model of the
// CIC (boxcar^3 impulse response) plus a handshake model, compared every cycle.
module tb_pdm_cic_decimator;

    localparam int R    = 256;
    localparam int NTAP = 3 * R - 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pdm_in = 1'b0;
    logic        pdm_ce = 1'b0;
    logic        pcm_ready = 1'b1;
    logic [15:0] pcm_out;
    logic        pcm_valid;
    logic        overrun;

    pdm_cic_decimator #(.DECIM_LOG2(8), .OUT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pdm_in    (pdm_in),
        .pdm_ce    (pdm_ce),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .overrun   (overrun)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          h[NTAP];
    int          xs[$];
    int          cyc = 0;
    int          m_ce_n = 0;
    int          m_ticks = 0;
    int          m_tick4_cyc = -1;
    bit          m_p1 = 1'b0, m_p2 = 1'b0;
    bit          pend_on = 1'b0;
    int          pend_at = 0;
    int          pend_y = 0;
    bit          m_valid = 1'b0, m_ovr = 1'b0;
    logic [15:0] m_out = 16'h0;

    function automatic int model_y();
        longint raw;
        int     n;
        int     y;
        raw = 0;
        n   = xs.size();
        for (int i = 0; i < NTAP; i++) begin
            int j;
            j = n - 2 - i;
            if (j >= 1) raw += longint'(h[i]) * longint'(xs[j-1]);
        end
        y = int'(raw >>> 9);
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    initial begin
        int h2[2*R-1];
        foreach (h2[i]) h2[i] = 0;
        foreach (h[i]) h[i] = 0;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < R; j++) h2[i+j]++;
        for (int i = 0; i < 2*R-1; i++)
            for (int k = 0; k < R; k++) h[i+k] += h2[i];
    end

    // Model: advances on each rising edge from the inputs the DUT samples there.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            xs.delete();
            m_ce_n = 0; m_ticks = 0; m_tick4_cyc = -1;
            m_p1 = 0; m_p2 = 0; pend_on = 0;
            m_valid = 0; m_ovr = 0; m_out = 16'h0;
        end else begin
            if (pend_on && pend_at == cyc) begin
                pend_on = 0;
                if (m_valid && !pcm_ready) m_ovr = 1;
                m_out   = pend_y[15:0];
                m_valid = 1;
            end else if (m_valid && pcm_ready) begin
                m_valid = 0;
            end
            if (pdm_ce) begin
                xs.push_back(m_p2 ? 1 : -1);
                m_ce_n++;
                if (m_ce_n % R == 0) begin
                    m_ticks++;
                    if (m_ticks == 4) m_tick4_cyc = cyc;
                    if (m_ticks >= 4) begin
                        pend_on = 1;
                        pend_at = cyc + 4;
                        pend_y  = model_y();
                    end
                end
            end
            m_p2 = m_p1;
            m_p1 = pdm_in;
        end
    end

    // ---------------- compare process ----------------
    bit cmp_en = 1'b0;
    bit prev_valid = 1'b0;
    int last_rise = -1;
    int last_period = 0;

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("pcm_valid", {31'b0, pcm_valid}, {31'b0, m_valid});
            check("overrun", {31'b0, overrun}, {31'b0, m_ovr});
            check("pcm_out", {16'b0, pcm_out}, {16'b0, m_out});
            if (pcm_valid && !prev_valid) begin
                if (last_rise >= 0) last_period = cyc - last_rise;
                last_rise = cyc;
            end
            prev_valid = pcm_valid;
        end
    end

    // ---------------- stimulus ----------------
    int st = 0;
    bit cur_bit = 1'b0;

    function automatic bit pat_bit(input int pat, input int b);
        case (pat)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (b % 2) == 0;
            3:       return (b % 4) != 3;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Called right after a falling edge: sets the inputs for the next rising edge.
    task automatic drive(input int pat, input int ce_div, input int rdy_mode);
        if (st % ce_div == 0) cur_bit = pat_bit(pat, st / ce_div);
        pdm_in = cur_bit;
        pdm_ce = (st % ce_div) == 0;
        st++;
        case (rdy_mode)
            0:       pcm_ready = 1'b1;
            1:       pcm_ready = 1'b0;
            default: pcm_ready = pend_on && (pend_at == cyc + 1) && (m_ticks >= 5);
        endcase
    endtask

    task automatic run(input int cycles, input int pat, input int ce_div, input int rdy_mode);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            drive(pat, ce_div, rdy_mode);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pdm_ce = 1'b0;
        pcm_ready = 1'b1;
        st = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int  v;
        bit  found;

        // model pins: boxcar^3 has DC gain R^3 and starts 1, 3, ...
        #1;
        begin
            longint s;
            s = 0;
            foreach (h[i]) s += h[i];
            check("model_dc_gain", 32'(s), 32'd16777216);
            check("model_h0", 32'(h[0]), 32'd1);
            check("model_h1", 32'(h[1]), 32'd3);
        end

        do_reset();
        cmp_en = 1'b1;
        check("reset_pcm_out", {16'b0, pcm_out}, 32'h0);
        check("reset_valid", {31'b0, pcm_valid}, 32'h0);
        check("reset_overrun", {31'b0, overrun}, 32'h0);

        // constant ones -> positive full scale, one sample per R clocks
        run(7 * R, 1, 1, 0);
        check("ones_value", {16'b0, pcm_out}, 32'h7FFF);
        check("ones_period", 32'(last_period), 32'd256);

        // constant zeros -> negative full scale, no overrun with ready high
        do_reset();
        run(7 * R, 0, 1, 0);
        check("zeros_value", {16'b0, pcm_out}, 32'h8000);
        check("zeros_overrun", {31'b0, overrun}, 32'h0);

        // alternating -> exactly zero
        do_reset();
        run(7 * R, 2, 1, 0);
        check("alt_value", {16'b0, pcm_out}, 32'h0);

        // 75% density -> half scale
        do_reset();
        run(7 * R, 3, 1, 0);
        v = int'($signed(pcm_out));
        check("level_4000", {31'b0, (v >= 16384 - 64) && (v <= 16384 + 64)}, 32'd1);

        // never ready across several emits -> sticky overrun, last sample held
        do_reset();
        run(7 * R, 4, 1, 1);
        check("overrun_set", {31'b0, overrun}, 32'd1);
        check("overrun_valid", {31'b0, pcm_valid}, 32'd1);

        // ready only on the emit cycle -> consumed and reloaded, no overrun
        do_reset();
        run(8 * R, 4, 1, 2);
        check("ready_on_emit_ovr", {31'b0, overrun}, 32'd0);
        check("ready_on_emit_valid", {31'b0, pcm_valid}, 32'd1);

        // reset while the comb is in its second stage
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 6 * R; k++) begin
            @(negedge clk);
            drive(1, 1, 0);
            if (m_ticks == 5) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_tick5", {31'b0, found}, 32'd1);
        @(negedge clk);
        drive(1, 1, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        st = 0;
        drive(1, 1, 0);
        check("midrst_pcm_out", {16'b0, pcm_out}, 32'h0);
        check("midrst_valid", {31'b0, pcm_valid}, 32'h0);
        check("midrst_overrun", {31'b0, overrun}, 32'h0);
        run(4 * R + 20, 1, 1, 0);
        check("midrst_latency", 32'(last_rise - m_tick4_cyc), 32'd4);

        // PDM enable every 4th clock: same levels, four times the emit period
        do_reset();
        run(7 * 4 * R, 1, 4, 0);
        check("ce4_ones_value", {16'b0, pcm_out}, 32'h7FFF);
        check("ce4_ones_period", 32'(last_period), 32'd1024);
        do_reset();
        run(7 * 4 * R, 0, 4, 0);
        check("ce4_zeros_value", {16'b0, pcm_out}, 32'h8000);
        do_reset();
        run(7 * 4 * R, 2, 4, 0);
        check("ce4_alt_value", {16'b0, pcm_out}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
